// File: rtl/count_down_timer_ex.sv
// count_down_timer_ex: BCD countdown timer with pause/resume, auto-repeat, ring auto-timeout,
// one-cycle expiry pulse and preset saturation. Define TIMER_WARN_EN to enable the warn output.
module count_down_timer_ex #(
  parameter int unsigned CLK_HZ    = 50_000_000,
  parameter int unsigned RING_SECS = 10,
  parameter int unsigned WARN_SECS = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       set,
  input  logic       play,
  input  logic       stop,
  input  logic       repeat_mode,
  input  logic [7:0] hour_bcd_in,
  input  logic [7:0] minute_bcd_in,
  input  logic [7:0] second_bcd_in,
  output logic [7:0] hour_out_bcd,
  output logic [7:0] minute_out_bcd,
  output logic [7:0] second_out_bcd,
  output logic       counting,
  output logic       ring,
  output logic       expired,
  output logic       warn
);

  // state | meaning
  // IDLE  | preset loaded, not counting
  // RUN   | counting down, prescaler advancing
  // PAUSE | counting suspended, prescaler held for sub-second resume
  // RING  | expired without repeat, display 00:00:00, ring may be active

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int RW = (RING_SECS > 1) ? $clog2(RING_SECS + 1) : 1;
  localparam bit RING_AUTO = (RING_SECS != 0);

  if (CLK_HZ < 2 || WARN_SECS < 1 || WARN_SECS > 59) begin : g_param_check
    $error("count_down_timer_ex: CLK_HZ must be >= 2 and WARN_SECS within 1..59");
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_RING  = 2'd3
  } state_e;

  function automatic logic [7:0] clamp_digits(input logic [7:0] v);
    logic [3:0] tens, ones;
    tens = (v[7:4] > 4'd9) ? 4'd9 : v[7:4];
    ones = (v[3:0] > 4'd9) ? 4'd9 : v[3:0];
    return {tens, ones};
  endfunction

  function automatic logic [7:0] clamp_59(input logic [7:0] v);
    logic [7:0] c;
    c = clamp_digits(v);
    return (c[7:4] > 4'd5) ? 8'h59 : c;
  endfunction

  function automatic logic [7:0] dec2(input logic [7:0] v, input logic [7:0] wrap);
    if (v[3:0] != 4'd0) begin
      return {v[7:4], v[3:0] - 4'd1};
    end else if (v[7:4] != 4'd0) begin
      return {v[7:4] - 4'd1, 4'd9};
    end else begin
      return wrap;
    end
  endfunction

  // One-second BCD decrement with borrow through minutes into hours.
  function automatic logic [23:0] dec_time(input logic [23:0] t);
    logic [7:0] hh, mm, ss;
    hh = t[23:16];
    mm = t[15:8];
    ss = t[7:0];
    if (ss == 8'h00) begin
      if (mm == 8'h00) begin
        hh = dec2(hh, 8'h00);
      end
      mm = dec2(mm, 8'h59);
    end
    ss = dec2(ss, 8'h59);
    return {hh, mm, ss};
  endfunction

  state_e        state_q, state_d;
  logic [23:0]   preset_q, preset_d;
  logic [23:0]   time_q, time_d;
  logic [PW-1:0] presc_q, presc_d, presc_inc;
  logic [RW-1:0] ring_cnt_q, ring_cnt_d, ring_cnt_inc;
  logic          ring_q, ring_d;
  logic          expired_q, expired_d;
  logic          counting_q;
  logic          warn_q, warn_d;
  logic          tick, last_sec, ring_hit;
  logic [23:0]   preset_sat, time_dec;

  assign preset_sat   = {clamp_digits(hour_bcd_in), clamp_59(minute_bcd_in), clamp_59(second_bcd_in)};
  assign time_dec     = dec_time(time_q);
  assign tick         = (presc_q == PW'(CLK_HZ - 1));
  assign presc_inc    = tick ? '0 : presc_q + PW'(1);
  assign last_sec     = (time_q == 24'h00_00_01);
  assign ring_cnt_inc = ring_cnt_q + RW'(1);
  assign ring_hit     = RING_AUTO && (ring_cnt_inc == RW'(RING_SECS));

  always_comb begin
    state_d    = state_q;
    preset_d   = preset_q;
    time_d     = time_q;
    presc_d    = presc_q;
    ring_d     = ring_q;
    ring_cnt_d = ring_cnt_q;
    expired_d  = 1'b0;

    if (set) begin
      preset_d = preset_sat;
      time_d   = preset_sat;
      presc_d  = '0;
      ring_d   = 1'b0;
      state_d  = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (!stop && play && time_q != 24'h0) begin
            state_d = ST_RUN;
          end
        end

        ST_RUN: begin
          if (stop) begin
            state_d = ST_PAUSE;
          end else begin
            presc_d = presc_inc;
            if (tick) begin
              if (last_sec) begin
                expired_d  = 1'b1;
                ring_d     = 1'b1;
                ring_cnt_d = '0;
                if (repeat_mode) begin
                  time_d = preset_q;
                end else begin
                  time_d  = 24'h0;
                  state_d = ST_RING;
                end
              end else begin
                time_d = time_dec;
                // Ring from an earlier repeat expiry times out on the shared prescaler.
                if (ring_q && RING_AUTO) begin
                  ring_cnt_d = ring_cnt_inc;
                  if (ring_hit) ring_d = 1'b0;
                end
              end
            end
          end
        end

        ST_PAUSE: begin
          if (stop) begin
            time_d  = preset_q;
            presc_d = '0;
            ring_d  = 1'b0;
            state_d = ST_IDLE;
          end else if (play) begin
            state_d = ST_RUN;
          end
        end

        ST_RING: begin
          if (stop) begin
            ring_d  = 1'b0;
            time_d  = preset_q;
            presc_d = '0;
            state_d = ST_IDLE;
          end else if (play) begin
            ring_d  = 1'b0;
            time_d  = preset_q;
            presc_d = '0;
            state_d = (preset_q != 24'h0) ? ST_RUN : ST_IDLE;
          end else if (ring_q) begin
            presc_d = presc_inc;
            if (tick && RING_AUTO) begin
              ring_cnt_d = ring_cnt_inc;
              if (ring_hit) ring_d = 1'b0;
            end
          end
        end

        default: state_d = ST_IDLE;
      endcase
    end
  end

`ifdef TIMER_WARN_EN
  logic [7:0] ss_bin_d;
  logic       in_window;

  assign ss_bin_d  = 8'(time_d[7:4]) * 8'd10 + 8'(time_d[3:0]);
  assign in_window = (time_d[23:8] == 16'h0) && (ss_bin_d != 8'd0) && (ss_bin_d <= 8'(WARN_SECS));

  always_comb begin
    warn_d = 1'b0;
    if (expired_d) begin
      warn_d = 1'b0;
    end else if (state_d == ST_PAUSE) begin
      warn_d = warn_q;
    end else if (state_d == ST_RUN) begin
      warn_d = in_window;
    end
  end
`else
  assign warn_d = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      preset_q   <= '0;
      time_q     <= '0;
      presc_q    <= '0;
      ring_q     <= 1'b0;
      ring_cnt_q <= '0;
      expired_q  <= 1'b0;
      counting_q <= 1'b0;
      warn_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      preset_q   <= preset_d;
      time_q     <= time_d;
      presc_q    <= presc_d;
      ring_q     <= ring_d;
      ring_cnt_q <= ring_cnt_d;
      expired_q  <= expired_d;
      counting_q <= (state_d == ST_RUN);
      warn_q     <= warn_d;
    end
  end

  assign hour_out_bcd   = time_q[23:16];
  assign minute_out_bcd = time_q[15:8];
  assign second_out_bcd = time_q[7:0];
  assign counting       = counting_q;
  assign ring           = ring_q;
  assign expired        = expired_q;
  assign warn           = warn_q;

endmodule

// File: tb/tb_count_down_timer_ex.sv
// Scoreboard bench for count_down_timer_ex: expected snapshots are queued against absolute
// cycle numbers while stimulus is driven, then popped and compared at the falling edge.
module tb_count_down_timer_ex;

  localparam int CLK_HZ    = 10;
  localparam int RING_SECS = 2;
  localparam int WARN_SECS = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       set = 1'b0;
  logic       play = 1'b0;
  logic       stop = 1'b0;
  logic       repeat_mode = 1'b0;
  logic [7:0] hh_i = 8'h00;
  logic [7:0] mm_i = 8'h00;
  logic [7:0] ss_i = 8'h00;
  logic [7:0] hour_out_bcd, minute_out_bcd, second_out_bcd;
  logic       counting, ring, expired, warn;
  logic [27:0] obs;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int b, p, q, e;

  typedef struct {
    int          cyc;
    string       tag;
    logic [27:0] exp;
  } exp_t;
  exp_t sb_q[$];

  count_down_timer_ex #(
    .CLK_HZ   (CLK_HZ),
    .RING_SECS(RING_SECS),
    .WARN_SECS(WARN_SECS)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .set           (set),
    .play          (play),
    .stop          (stop),
    .repeat_mode   (repeat_mode),
    .hour_bcd_in   (hh_i),
    .minute_bcd_in (mm_i),
    .second_bcd_in (ss_i),
    .hour_out_bcd  (hour_out_bcd),
    .minute_out_bcd(minute_out_bcd),
    .second_out_bcd(second_out_bcd),
    .counting      (counting),
    .ring          (ring),
    .expired       (expired),
    .warn          (warn)
  );

  assign obs = {hour_out_bcd, minute_out_bcd, second_out_bcd, counting, ring, expired, warn};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Expected warn level for a RUN display of 'secs' remaining seconds.
  function automatic logic wv(input logic run, input int secs);
`ifdef TIMER_WARN_EN
    return run && (secs >= 1) && (secs <= WARN_SECS);
`else
    return 1'b0;
`endif
  endfunction

  task automatic expect_at(input int c, input string tag, input logic [23:0] t,
                           input logic cnt, input logic r, input logic ex, input logic w);
    exp_t en;
    int   i;
    en.cyc = c;
    en.tag = tag;
    en.exp = {t, cnt, r, ex, w};
    i = 0;
    while (i < sb_q.size() && sb_q[i].cyc <= c) i++;
    sb_q.insert(i, en);
  endtask

  always @(negedge clk) begin : monitor
    exp_t en;
    while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
      en = sb_q.pop_front();
      if (en.cyc < cyc) check_val({en.tag, "_missed"}, cyc, en.cyc);
      else check_val(en.tag, {4'h0, obs}, {4'h0, en.exp});
    end
  end

  task automatic wait_cyc(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Drive controls for exactly one sampling edge; returns 2 ns after that edge.
  task automatic pulse(input logic s, input logic pl, input logic st);
    set  = s;
    play = pl;
    stop = st;
    @(posedge clk);
    #2;
    set  = 1'b0;
    play = 1'b0;
    stop = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    wait_cyc(3);
    expect_at(cyc, "reset", 24'h000000, 0, 0, 0, 0);
    rst = 1'b0;

    // Basic single-shot countdown, expiry pulse and ring timeout.
    hh_i = 8'h00; mm_i = 8'h00; ss_i = 8'h03;
    pulse(1, 0, 0);
    expect_at(cyc, "s1_set", 24'h000003, 0, 0, 0, 0);
    pulse(0, 1, 0);
    b = cyc;
    expect_at(b,      "s1_play",     24'h000003, 1, 0, 0, wv(1, 3));
    expect_at(b + 9,  "s1_pre_tick", 24'h000003, 1, 0, 0, wv(1, 3));
    expect_at(b + 10, "s1_tick1",    24'h000002, 1, 0, 0, wv(1, 2));
    expect_at(b + 20, "s1_tick2",    24'h000001, 1, 0, 0, wv(1, 1));
    expect_at(b + 29, "s1_pre_exp",  24'h000001, 1, 0, 0, wv(1, 1));
    expect_at(b + 30, "s1_expiry",   24'h000000, 0, 1, 1, 0);
    expect_at(b + 31, "s1_pulse_end",24'h000000, 0, 1, 0, 0);
    expect_at(b + 49, "s1_ring_held",24'h000000, 0, 1, 0, 0);
    expect_at(b + 50, "s1_ring_clr", 24'h000000, 0, 0, 0, 0);
    wait_cyc(b + 52);
    pulse(0, 0, 1);
    expect_at(cyc, "s1_ring_stop", 24'h000003, 0, 0, 0, 0);

    // Borrow chain, then saturated set while running.
    hh_i = 8'h01; mm_i = 8'h00; ss_i = 8'h00;
    pulse(1, 0, 0);
    pulse(0, 1, 0);
    b = cyc;
    expect_at(b + 10, "borrow", 24'h005959, 1, 0, 0, 0);
    wait_cyc(b + 12);
    hh_i = 8'hA3; mm_i = 8'h7A; ss_i = 8'h65;
    pulse(1, 0, 0);
    expect_at(cyc, "saturate", 24'h935959, 0, 0, 0, 0);

    // play+stop in IDLE, and play with a zero preset.
    pulse(0, 1, 1);
    e = cyc;
    expect_at(e,     "playstop_idle",  24'h935959, 0, 0, 0, 0);
    expect_at(e + 1, "playstop_idle2", 24'h935959, 0, 0, 0, 0);
    wait_cyc(e + 2);
    hh_i = 8'h00; mm_i = 8'h00; ss_i = 8'h00;
    pulse(1, 0, 0);
    pulse(0, 1, 0);
    expect_at(cyc,     "zero_play",  24'h000000, 0, 0, 0, 0);
    expect_at(cyc + 3, "zero_play2", 24'h000000, 0, 0, 0, 0);
    wait_cyc(cyc + 4);

    // Pause with sub-second resume, then double stop cancels back to the preset.
    ss_i = 8'h05;
    pulse(1, 0, 0);
    pulse(0, 1, 0);
    b = cyc;
    expect_at(b + 7,   "pre_pause",  24'h000005, 1, 0, 0, wv(1, 5));
    wait_cyc(b + 7);
    pulse(0, 0, 1);
    expect_at(b + 8,   "paused",     24'h000005, 0, 0, 0, wv(1, 5));
    expect_at(b + 100, "paused_long",24'h000005, 0, 0, 0, wv(1, 5));
    wait_cyc(b + 107);
    pulse(0, 1, 0);
    p = cyc;
    expect_at(p,     "resume",      24'h000005, 1, 0, 0, wv(1, 5));
    expect_at(p + 2, "resume_pre",  24'h000005, 1, 0, 0, wv(1, 5));
    expect_at(p + 3, "resume_tick", 24'h000004, 1, 0, 0, wv(1, 4));
    wait_cyc(p + 3);
    pulse(0, 0, 1);
    expect_at(cyc, "pause2", 24'h000004, 0, 0, 0, wv(1, 4));
    pulse(0, 0, 1);
    expect_at(cyc, "cancel", 24'h000005, 0, 0, 0, 0);
    pulse(0, 1, 0);
    q = cyc;
    expect_at(q + 9,  "fresh_pre",  24'h000005, 1, 0, 0, wv(1, 5));
    expect_at(q + 10, "fresh_tick", 24'h000004, 1, 0, 0, wv(1, 4));
    wait_cyc(q + 12);
    ss_i = 8'h07;
    pulse(1, 1, 0);
    expect_at(cyc,     "setplay_run",  24'h000007, 0, 0, 0, 0);
    expect_at(cyc + 1, "setplay_run2", 24'h000007, 0, 0, 0, 0);
    wait_cyc(cyc + 2);

    // Auto-repeat: periodic expiry, reload and ring re-trigger.
    repeat_mode = 1'b1;
    ss_i = 8'h02;
    pulse(1, 0, 0);
    pulse(0, 1, 0);
    b = cyc;
    expect_at(b,      "rep_play",  24'h000002, 1, 0, 0, wv(1, 2));
    expect_at(b + 10, "rep_t1",    24'h000001, 1, 0, 0, wv(1, 1));
    expect_at(b + 20, "rep_exp1",  24'h000002, 1, 1, 1, 0);
    expect_at(b + 21, "rep_after1",24'h000002, 1, 1, 0, wv(1, 2));
    expect_at(b + 30, "rep_t3",    24'h000001, 1, 1, 0, wv(1, 1));
    expect_at(b + 40, "rep_exp2",  24'h000002, 1, 1, 1, 0);
    expect_at(b + 59, "rep_pre3",  24'h000001, 1, 1, 0, wv(1, 1));
    expect_at(b + 60, "rep_exp3",  24'h000002, 1, 1, 1, 0);
    expect_at(b + 61, "rep_after3",24'h000002, 1, 1, 0, wv(1, 2));
    wait_cyc(b + 64);
    rst = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b0;
    repeat_mode = 1'b0;
    expect_at(cyc,     "rst_run",  24'h000000, 0, 0, 0, 0);
    expect_at(cyc + 1, "rst_run2", 24'h000000, 0, 0, 0, 0);
    wait_cyc(cyc + 2);

    // Warning window, then play from RING restarts the preset.
    ss_i = 8'h05;
    pulse(1, 0, 0);
    pulse(0, 1, 0);
    b = cyc;
    expect_at(b + 10, "warn_4",   24'h000004, 1, 0, 0, wv(1, 4));
    expect_at(b + 19, "warn_4b",  24'h000004, 1, 0, 0, wv(1, 4));
    expect_at(b + 20, "warn_3",   24'h000003, 1, 0, 0, wv(1, 3));
    expect_at(b + 30, "warn_2",   24'h000002, 1, 0, 0, wv(1, 2));
    expect_at(b + 40, "warn_1",   24'h000001, 1, 0, 0, wv(1, 1));
    expect_at(b + 50, "warn_exp", 24'h000000, 0, 1, 1, 0);
    wait_cyc(b + 52);
    pulse(0, 1, 0);
    expect_at(cyc,      "ring_play",      24'h000005, 1, 0, 0, wv(1, 5));
    expect_at(cyc + 10, "ring_play_tick", 24'h000004, 1, 0, 0, wv(1, 4));
    wait_cyc(cyc + 13);

    check_val("sb_left", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
